// File: rtl/nes_bus_pkg.sv
// Shared types and parameter checks for the bus-attached RAM model.
package nes_bus_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    IDLE,
    WAIT
  } bus_state_e;

  function automatic bit params_ok(
    input int unsigned     addr_w,
    input int unsigned     depth_log2,
    input int unsigned     window_log2,
    input int unsigned     rd_lat,
    input int unsigned     wait_st,
    input longint unsigned base
  );
    longint unsigned win;
    win = 64'd1 << window_log2;
    return (rd_lat >= 1) && (rd_lat <= 4) &&
           (wait_st <= 15) &&
           (depth_log2 <= window_log2) &&
           (window_log2 <= addr_w) &&
           ((base % win) == 0);
  endfunction

endpackage

// File: rtl/nes_bus_read_pipe.sv
// Read data delay line: {valid, data} shifted every cycle, cleared on reset.
module nes_bus_read_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0] v_q;
  logic [DATA_W-1:0] d_q [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      d_q[0] <= in_data;
      for (int i = 1; i < int'(STAGES); i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];

endmodule

// File: rtl/nes_bus_ram.sv
// Bus-attached RAM/ROM with mirrored window decode, wait states,
// configurable read latency and a saturating write counter.
module nes_bus_ram
  import nes_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       DEPTH_LOG2   = 11,
  parameter int unsigned       WINDOW_LOG2  = 13,
  parameter logic [ADDR_W-1:0] BASE         = '0,
  parameter int unsigned       READ_LATENCY = 1,
  parameter int unsigned       WAIT_STATES  = 0,
  parameter bit                READ_ONLY    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              hit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [15:0]       write_count
);

  localparam int unsigned CNT_W   = 4;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  if (!params_ok(ADDR_W, DEPTH_LOG2, WINDOW_LOG2,
                 READ_LATENCY, WAIT_STATES, 64'(BASE)))
  begin : g_bad_params
    $error("nes_bus_ram: illegal parameter set");
  end

  logic [DATA_W-1:0] memory [2**DEPTH_LOG2];

  bus_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  rw_q;
  logic [DATA_W-1:0]     din_q;
  logic                  hit_q;
  logic [15:0]           wc_q, wc_d;

  logic                  accept;
  logic                  exec;
  logic [DEPTH_LOG2-1:0] ex_idx;
  logic                  ex_rw;
  logic [DATA_W-1:0]     ex_din;
  logic                  ex_hit;
  logic                  do_read;
  logic                  do_write;
  logic [DATA_W-1:0]     rd_data;

  // Whole-address shift keeps the mirror bits out of the compare.
  assign hit    = (addr >> WINDOW_LOG2) == (BASE >> WINDOW_LOG2);
  assign ready  = (state_q == IDLE);
  assign accept = req & ready & ~reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            exec = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero wait states execute straight from the bus.
  assign ex_idx = NO_WAIT ? addr[DEPTH_LOG2-1:0] : idx_q;
  assign ex_rw  = NO_WAIT ? rw      : rw_q;
  assign ex_din = NO_WAIT ? data_in : din_q;
  assign ex_hit = NO_WAIT ? hit     : hit_q;

  assign do_read  = exec & ex_hit & (ex_rw == RW_READ);
  assign do_write = exec & ex_hit & (ex_rw == RW_WRITE) & ~READ_ONLY;
  assign rd_data  = do_read ? memory[ex_idx] : '0;
  assign wc_d     = (do_write && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;

  always_ff @(posedge clock) begin
    if (do_write) begin
      memory[ex_idx] <= ex_din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= RW_READ;
      din_q   <= '0;
      hit_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      if (accept) begin
        idx_q <= addr[DEPTH_LOG2-1:0];
        rw_q  <= rw;
        din_q <= data_in;
        hit_q <= hit;
      end
    end
  end

  assign write_count = wc_q;

  nes_bus_read_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LATENCY)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (do_read),
    .in_data   (rd_data),
    .out_valid (data_valid),
    .out_data  (data_out)
  );

endmodule

// File: tb/tb_nes_bus_ram.sv
// Bench for nes_bus_ram: four configurations share one bus and are
// checked every cycle against a scheduled-access reference model.
module tb_nes_bus_ram;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;

  logic        ready_w [4];
  logic        hit_w   [4];
  logic        dv_w    [4];
  logic [7:0]  dout_w  [4];
  logic [15:0] wc_w    [4];

  always #5 clock = ~clock;

  nes_bus_ram u_def (
    .clock, .reset, .req, .addr, .rw, .data_in,
    .ready(ready_w[0]), .hit(hit_w[0]), .data_out(dout_w[0]),
    .data_valid(dv_w[0]), .write_count(wc_w[0])
  );

  nes_bus_ram #(.READ_LATENCY(3), .WAIT_STATES(2)) u_ws (
    .clock, .reset, .req, .addr, .rw, .data_in,
    .ready(ready_w[1]), .hit(hit_w[1]), .data_out(dout_w[1]),
    .data_valid(dv_w[1]), .write_count(wc_w[1])
  );

  nes_bus_ram #(.READ_LATENCY(2), .READ_ONLY(1'b1)) u_rom (
    .clock, .reset, .req, .addr, .rw, .data_in,
    .ready(ready_w[2]), .hit(hit_w[2]), .data_out(dout_w[2]),
    .data_valid(dv_w[2]), .write_count(wc_w[2])
  );

  nes_bus_ram #(.READ_LATENCY(4), .WAIT_STATES(3)) u_w3 (
    .clock, .reset, .req, .addr, .rw, .data_in,
    .ready(ready_w[3]), .hit(hit_w[3]), .data_out(dout_w[3]),
    .data_valid(dv_w[3]), .write_count(wc_w[3])
  );

  int ws_p [4] = '{0, 2, 0, 3};
  int rl_p [4] = '{1, 3, 2, 4};
  bit ro_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [7:0]  mm [4][2048];
  int          rdy_from [4];
  int          wc_m [4];
  bit          ex_v   [4][16];
  bit          ex_rd  [4][16];
  bit          ex_hit [4][16];
  logic [10:0] ex_idx [4][16];
  logic [7:0]  ex_d   [4][16];
  bit          ov [4][16];
  logic [7:0]  od [4][16];
  int          e = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    bit          rq;
    logic [15:0] a;
    bit          r;
    logic [7:0]  d;
    bit          hit;
    logic [7:0]  dout;
    bit          dv;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [7:0] pre(input int i);
    case (i)
      'h021:   return 8'h31;
      'h7FF:   return 8'h5C;
      default: return 8'(i * 13 + 5);
    endcase
  endfunction

  function automatic logic [7:0] mem_of(input int n, input int i);
    case (n)
      0:       return u_def.memory[i];
      1:       return u_ws.memory[i];
      2:       return u_rom.memory[i];
      default: return u_w3.memory[i];
    endcase
  endfunction

  task automatic chk(input string name, input int n,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h t=%0t",
               name, n, got, exp, $time);
    end
  endtask

  // One bus cycle: model decides acceptance/execution, then outputs
  // after the edge are compared for all four instances.
  task automatic step(input bit rq, input logic [15:0] a,
                      input bit r, input logic [7:0] d);
    int s;
    int o;
    bit in_win;
    req = rq; addr = a; rw = r; data_in = d;
    in_win = (a[15:13] == 3'd0);
    for (int n = 0; n < 4; n++) begin
      if (rq && (e - 1 >= rdy_from[n])) begin
        s = (e + ws_p[n]) % 16;
        ex_v[n][s]   = 1'b1;
        ex_rd[n][s]  = r;
        ex_hit[n][s] = in_win;
        ex_idx[n][s] = a[10:0];
        ex_d[n][s]   = d;
        rdy_from[n]  = e + ws_p[n];
      end
      s = e % 16;
      if (ex_v[n][s]) begin
        ex_v[n][s] = 1'b0;
        if (ex_hit[n][s]) begin
          if (ex_rd[n][s]) begin
            o = (e + rl_p[n] - 1) % 16;
            ov[n][o] = 1'b1;
            od[n][o] = mm[n][ex_idx[n][s]];
          end else if (!ro_p[n]) begin
            mm[n][ex_idx[n][s]] = ex_d[n][s];
            if (wc_m[n] < 65535) wc_m[n]++;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    for (int n = 0; n < 4; n++) begin
      s = e % 16;
      chk("ready", n, ready_w[n], e >= rdy_from[n]);
      chk("data_valid", n, dv_w[n], ov[n][s]);
      chk("data_out", n, dout_w[n], ov[n][s] ? od[n][s] : 8'h00);
      chk("write_count", n, wc_w[n], wc_m[n]);
      chk("hit", n, hit_w[n], in_win);
      ov[n][s] = 1'b0;
      od[n][s] = '0;
    end
    e++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      chk("rst_ready", n, ready_w[n], 1);
      chk("rst_data_out", n, dout_w[n], 0);
      chk("rst_data_valid", n, dv_w[n], 0);
      chk("rst_write_count", n, wc_w[n], 0);
    end
    @(posedge clock);
    e++;
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      rdy_from[n] = e - 1;
      wc_m[n] = 0;
      for (int k = 0; k < 16; k++) begin
        ex_v[n][k] = 1'b0;
        ov[n][k] = 1'b0;
        od[n][k] = '0;
      end
    end
  endtask

  initial begin : main
    bit exp_rdy [6];
    bit exp_dv  [6];
    logic [15:0] ra;

    for (int i = 0; i < 2048; i++) begin
      u_def.memory[i] = pre(i);
      u_ws.memory[i]  = pre(i);
      u_rom.memory[i] = pre(i);
      u_w3.memory[i]  = pre(i);
      for (int n = 0; n < 4; n++) mm[n][i] = pre(i);
    end

    do_reset();

    tbl[0]  = '{1'b1, 16'h0821, 1'b1, 8'h00, 1'b1, 8'h31, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 16'h1821, 1'b1, 8'h00, 1'b1, 8'h31, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 16'h1805, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 16'h0005, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 16'h2000, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 16'h2000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 16'd1};
    tbl[6]  = '{1'b0, 16'h0021, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 16'h1FFF, 1'b1, 8'h00, 1'b1, 8'h5C, 1'b1, 16'd1};
    tbl[8]  = '{1'b1, 16'h0000, 1'b0, 8'hE7, 1'b1, 8'h00, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 16'h0800, 1'b1, 8'h00, 1'b1, 8'hE7, 1'b1, 16'd2};
    tbl[10] = '{1'b1, 16'hE021, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 16'h1021, 1'b1, 8'h00, 1'b1, 8'h31, 1'b1, 16'd2};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rq, tbl[i].a, tbl[i].r, tbl[i].d);
      chk("tbl_hit", i, hit_w[0], tbl[i].hit);
      chk("tbl_data_out", i, dout_w[0], tbl[i].dout);
      chk("tbl_data_valid", i, dv_w[0], tbl[i].dv);
      chk("tbl_write_count", i, wc_w[0], tbl[i].wc);
    end

    do_reset();
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_dv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0021, 1'b1, 8'h00);
      chk("ws_ready", i, ready_w[1], exp_rdy[i]);
      chk("ws_valid", i, dv_w[1], exp_dv[i]);
      if (exp_dv[i]) chk("ws_data", i, dout_w[1], 8'h31);
      chk("def_latency_data", i, dout_w[0], 8'h31);
    end

    step(1'b1, 16'h0010, 1'b0, 8'h99);
    step(1'b0, 16'h0000, 1'b1, 8'h00);
    chk("rom_mem", 2, mem_of(2, 'h010), pre('h010));
    chk("rom_write_count", 2, wc_w[2], 0);
    chk("ram_mem", 0, mem_of(0, 'h010), 8'h99);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
      else ra = 16'($urandom_range(0, 16'h1FFF));
      step($urandom_range(0, 3) != 0, ra,
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    do_reset();
    for (int n = 0; n < 4; n++) begin
      chk("survive_mem", n, mem_of(n, 'h021), mm[n]['h021]);
    end

    step(1'b1, 16'h0030, 1'b0, 8'hC3);
    step(1'b0, 16'h0000, 1'b1, 8'h00);
    do_reset();
    chk("midwait_mem", 3, mem_of(3, 'h030), mm[3]['h030]);
    chk("midwait_not_c3", 3, mem_of(3, 'h030) == 8'hC3, mm[3]['h030] == 8'hC3);

    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 16'h0100, 1'b0, 8'(i));
    end
    chk("saturate", 0, wc_w[0], 16'hFFFF);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2048; i++) begin
        chk("final_mem", n * 4096 + i, mem_of(n, i), mm[n][i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
